keypad_entry_receiver: RTL and testbench

//  Consumer side of the keypad encoder's d/dav interface. Debounces dav, accepts
//  one key per press and shifts decimal digits into an NDIG-digit BCD entry

---
 rtl/keypad_entry_receiver.sv | 120 ++++++++++++
 tb/tb_keypad_entry_receiver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_receiver.sv
// Debounces the keypad encoder's d/dav handshake, accepts one key per press and
// assembles BCD digits into an entry buffer that is committed on '#' (4'hF).
module keypad_entry_receiver #(
  parameter int NDIG     = 4,
  parameter int DEBOUNCE = 4,
  parameter int RELEASE  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  d,
  input  logic                        dav,
  output logic                        key_strobe,
  output logic [3:0]                  key_code,
  output logic [4*NDIG-1:0]           entry,
  output logic [$clog2(NDIG+1)-1:0]   digit_count,
  output logic                        overflow,
  output logic [4*NDIG-1:0]           value,
  output logic                        value_valid
);

  localparam int EW   = 4 * NDIG;
  localparam int DCW  = $clog2(NDIG + 1);
  localparam int MAXC = ((DEBOUNCE > RELEASE) ? DEBOUNCE : RELEASE) + 1;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    code;
  logic          accept;

  // Accept fires on the DEBOUNCE-th consecutive sample of an unchanged code;
  // in both accepting states d equals the code being accepted.
  always_comb begin
    accept = 1'b0;
    case (state)
      IDLE:    accept = dav && (DEBOUNCE == 1);
      DEB:     accept = dav && (d == code) && (int'(cnt) + 1 >= DEBOUNCE);
      default: accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= REL;
      cnt         <= '0;
      code        <= '0;
      key_strobe  <= 1'b0;
      key_code    <= '0;
      entry       <= '0;
      digit_count <= '0;
      overflow    <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      key_strobe  <= 1'b0;
      value_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (dav) begin
            code  <= d;
            cnt   <= CW'(1);
            state <= (DEBOUNCE == 1) ? HELD : DEB;
          end
        end
        DEB: begin
          if (!dav) begin
            state <= IDLE;
          end else if (d != code) begin
            code <= d;
            cnt  <= CW'(1);
          end else if (accept) begin
            state <= HELD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!dav) begin
            cnt   <= CW'(1);
            state <= REL;
          end
        end
        REL: begin
          // Any dav during release is treated as contact bounce of the same key.
          if (dav) begin
            state <= HELD;
          end else if (int'(cnt) + 1 >= RELEASE) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= REL;
      endcase

      if (accept) begin
        key_strobe <= 1'b1;
        key_code   <= d;
        if (d <= 4'd9) begin
          if (digit_count < DCW'(NDIG)) begin
            entry       <= (entry << 4) | EW'(d);
            digit_count <= digit_count + DCW'(1);
          end else begin
            overflow <= 1'b1;
          end
        end else if (d == 4'hF && digit_count != '0) begin
          value       <= entry;
          value_valid <= 1'b1;
          entry       <= '0;
          digit_count <= '0;
          overflow    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_receiver.sv
// Directed bench for keypad_entry_receiver: a per-cycle vector table for the
// debounce/release timing, then press-level sequences for entry and commit.
module tb_keypad_entry_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  d;
  logic        dav;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        overflow;
  logic [15:0] value;
  logic        value_valid;

  int tests = 0;
  int fails = 0;
  int n_str, n_vv;

  keypad_entry_receiver #(.NDIG(4), .DEBOUNCE(4), .RELEASE(4)) dut (
    .clk(clk), .reset(reset), .d(d), .dav(dav),
    .key_strobe(key_strobe), .key_code(key_code), .entry(entry),
    .digit_count(digit_count), .overflow(overflow), .value(value),
    .value_valid(value_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          dv;
    logic [3:0]  dd;
    logic [41:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [41:0] ex(bit s, logic [3:0] c, logic [15:0] e,
                                     logic [2:0] n, bit o, logic [15:0] v, bit vv);
    return {s, c, e, n, o, v, vv};
  endfunction

  function automatic logic [41:0] outs();
    return {key_strobe, key_code, entry, digit_count, overflow, value, value_valid};
  endfunction

  task automatic add(int n, bit r, bit dv, logic [3:0] dd, logic [41:0] e);
    vec_t v;
    v.rst_n = r; v.dv = dv; v.dd = dd; v.exp = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(string name, logic [41:0] act, logic [41:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, return 1 ns after the rising edge.
  task automatic cyc(bit r, bit dv, logic [3:0] dd);
    @(negedge clk);
    reset = r; dav = dv; d = dd;
    @(posedge clk);
    #1;
  endtask

  // A full press: 6 cycles held, 6 released; counts strobe and commit pulses.
  task automatic press(logic [3:0] k);
    n_str = 0; n_vv = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, (i < 6), (i < 6) ? k : 4'h0);
      if (key_strobe) n_str++;
      if (value_valid) n_vv++;
    end
  endtask

  logic [41:0] z, s5, s57, s578;

  initial begin
    reset = 1'b0; dav = 1'b0; d = 4'h0;
    z    = ex(0, 4'h0, 16'h0000, 3'd0, 0, 16'h0, 0);
    s5   = ex(0, 4'h5, 16'h0005, 3'd1, 0, 16'h0, 0);
    s57  = ex(0, 4'h7, 16'h0057, 3'd2, 0, 16'h0, 0);
    s578 = ex(0, 4'h8, 16'h0578, 3'd3, 0, 16'h0, 0);

    // Key held through reset is never captured; a fresh press is.
    add(20, 0, 1, 4'h5, z);
    add(3,  1, 1, 4'h5, z);
    add(4,  1, 0, 4'h0, z);
    add(3,  1, 1, 4'h5, z);
    add(1,  1, 1, 4'h5, ex(1, 4'h5, 16'h0005, 3'd1, 0, 16'h0, 0));
    add(1,  1, 1, 4'h5, s5);
    add(4,  1, 0, 4'h0, s5);
    // Press bounce 1,1,0,1,1,1,1 then release bounce 0,0,1,0,0,0,0.
    add(2,  1, 1, 4'h7, s5);
    add(1,  1, 0, 4'h0, s5);
    add(3,  1, 1, 4'h7, s5);
    add(1,  1, 1, 4'h7, ex(1, 4'h7, 16'h0057, 3'd2, 0, 16'h0, 0));
    add(1,  1, 1, 4'h7, s57);
    add(2,  1, 0, 4'h0, s57);
    add(1,  1, 1, 4'h7, s57);
    add(6,  1, 0, 4'h0, s57);
    // Code changes 3->8 on the second debounce sample.
    add(1,  1, 1, 4'h3, s57);
    add(3,  1, 1, 4'h8, s57);
    add(1,  1, 1, 4'h8, ex(1, 4'h8, 16'h0578, 3'd3, 0, 16'h0, 0));
    add(1,  1, 1, 4'h8, s578);
    add(4,  1, 0, 4'h0, s578);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst_n, vecs[i].dv, vecs[i].dd);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset clears the entry built above.
    cyc(1'b0, 1'b0, 4'h0);
    chk("reset_clear", outs(), z);
    repeat (4) cyc(1'b1, 1'b0, 4'h0);

    // 1,2,3 then '#'.
    press(4'h1); chk("p1_strobes", 42'(n_str), 42'd1);
    press(4'h2);
    press(4'h3);
    chk("e123", {26'h0, entry}, {26'h0, 16'h0123});
    chk("c123", 42'(digit_count), 42'd3);
    press(4'hF);
    chk("commit_vv", 42'(n_vv), 42'd1);
    chk("commit_val", {26'h0, value}, {26'h0, 16'h0123});
    chk("commit_clr", {25'h0, entry, digit_count}, 42'h0);

    // Five digits into a four-digit buffer.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("no_ovf4", 42'(overflow), 42'd0);
    press(4'h5);
    chk("ovf_set", 42'(overflow), 42'd1);
    chk("ovf_entry", {26'h0, entry}, {26'h0, 16'h1234});
    chk("ovf_cnt", 42'(digit_count), 42'd4);
    press(4'hF);
    chk("ovf_val", {26'h0, value}, {26'h0, 16'h1234});
    chk("ovf_clr", 42'(overflow), 42'd0);

    // '#' on an empty entry: strobe only.
    press(4'hF);
    chk("empty_str", 42'(n_str), 42'd1);
    chk("empty_code", 42'(key_code), 42'hF);
    chk("empty_vv", 42'(n_vv), 42'd0);
    chk("empty_val", {26'h0, value}, {26'h0, 16'h1234});

    // Non-digit, non-'#' key leaves the entry alone.
    press(4'h9);
    press(4'hA);
    chk("a_str", 42'(n_str), 42'd1);
    chk("a_code", 42'(key_code), 42'hA);
    chk("a_entry", {23'h0, entry, digit_count}, {23'h0, 16'h0009, 3'd1});

    // Reset mid-entry with a key down discards everything.
    cyc(1'b1, 1'b1, 4'h6);
    cyc(1'b0, 1'b1, 4'h6);
    chk("reset_mid", outs(), z);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
